// File: rtl/down_timer12_pkg.sv
// rtl/down_timer12_pkg.sv - shared width default and state encoding for the down timer
package down_timer12_pkg;

  localparam int DEFAULT_WIDTH = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/down_timer12.sv
// rtl/down_timer12.sv - loadable down counter with stop, auto-reload and terminal-count pulse
module down_timer12
  import down_timer12_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             expired,
  output logic             tc
);

  state_t           state, state_next;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] reload_reg, reload_next;
  logic             tc_next;

  // start wins over everything; stop wins over enable while running.
  always_comb begin
    state_next  = state;
    count_next  = count;
    reload_next = reload_reg;
    tc_next     = 1'b0;
    if (start) begin
      reload_next = load;
      if (load == '0) begin
        count_next = '0;
        state_next = ST_DONE;
        tc_next    = 1'b1;
      end else begin
        count_next = load;
        state_next = ST_RUN;
      end
    end else if (state == ST_RUN) begin
      if (stop) begin
        state_next = ST_IDLE;
      end else if (enable) begin
        if (count > WIDTH'(1)) begin
          count_next = count - WIDTH'(1);
        end else begin
          // count is never 0 in RUN, so this branch is the count==1 expiry
          tc_next = 1'b1;
          if (auto_reload) begin
            count_next = reload_reg;
          end else begin
            count_next = '0;
            state_next = ST_DONE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      count      <= '0;
      reload_reg <= '0;
      tc         <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      reload_reg <= reload_next;
      tc         <= tc_next;
    end
  end

  assign busy    = (state == ST_RUN);
  assign expired = (state == ST_DONE);

endmodule

// File: tb/tb_down_timer12.sv
// tb/tb_down_timer12.sv - randomized and directed self-checking bench for down_timer12
module tb_down_timer12;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] load = '0;
  logic [W-1:0] count;
  logic         busy;
  logic         expired;
  logic         tc;

  int pass_cnt = 0;
  int total = 0;

  // reference model: 0 idle, 1 running, 2 done
  int m_state = 0;
  int m_count = 0;
  int m_reload = 0;
  bit m_tc = 1'b0;

  down_timer12 #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .start(start),
    .stop(stop),
    .auto_reload(auto_reload),
    .load(load),
    .count(count),
    .busy(busy),
    .expired(expired),
    .tc(tc)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 0;
    m_count = 0;
    m_reload = 0;
    m_tc = 1'b0;
  endtask

  task automatic model_edge();
    m_tc = 1'b0;
    if (start) begin
      m_reload = int'(load);
      m_count = int'(load);
      if (load == 0) begin
        m_state = 2;
        m_tc = 1'b1;
      end else begin
        m_state = 1;
      end
    end else if (m_state == 1 && stop) begin
      m_state = 0;
    end else if (m_state == 1 && enable) begin
      m_count = m_count - 1;
      if (m_count == 0) begin
        m_tc = 1'b1;
        if (auto_reload) m_count = m_reload;
        else m_state = 2;
      end
    end
  endtask

  function automatic logic [W+2:0] exp_vec();
    return {W'(m_count), (m_state == 1), (m_state == 2), m_tc};
  endfunction

  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    model_reset();
    total++;
    if ({count, busy, expired, tc} !== {W'(0), 3'b000})
      $display("FAIL reset_async got count=%0d busy=%b expired=%b tc=%b exp all zero", count, busy, expired, tc);
    else pass_cnt++;
    step();
    step();
    reset = 1'b0;
    total++;
    if ({count, busy, expired, tc} !== exp_vec())
      $display("FAIL reset_held got %h exp %h", {count, busy, expired, tc}, exp_vec());
    else pass_cnt++;
  endtask

  task automatic test_basic();
    start = 1'b1; load = W'(5); enable = 1'b1; auto_reload = 1'b0;
    step();
    start = 1'b0; load = W'($urandom_range(1, 4000));
    total++;
    if ({count, busy, tc} !== {W'(5), 2'b10})
      $display("FAIL basic_load got count=%0d busy=%b tc=%b exp 5 1 0", count, busy, tc);
    else pass_cnt++;
    for (int i = 1; i <= 7; i++) begin
      step();
      total++;
      if ({count, expired, tc} !== {W'((i < 5) ? 5 - i : 0), (i >= 5), (i == 5)} || exp_vec() !== {count, busy, expired, tc})
        $display("FAIL basic_edge%0d got count=%0d expired=%b tc=%b exp %0d %b %b", i, count, expired, tc, (i < 5) ? 5 - i : 0, i >= 5, i == 5);
      else pass_cnt++;
    end
  endtask

  task automatic test_auto_reload();
    start = 1'b1; load = W'(3); enable = 1'b1; auto_reload = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      total++;
      if ({busy, tc} !== {1'b1, (i % 3 == 0)} || {count, busy, expired, tc} !== exp_vec())
        $display("FAIL reload_edge%0d got count=%0d busy=%b tc=%b exp count=%0d busy=1 tc=%b", i, count, busy, tc, m_count, i % 3 == 0);
      else pass_cnt++;
    end
    auto_reload = 1'b0;
  endtask

  task automatic test_enable_toggle();
    start = 1'b1; load = W'(4); enable = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      enable = (i % 2 == 0);
      step();
      total++;
      if ({count, tc} !== {W'((i >= 6) ? 0 : 4 - (i / 2 + 1)), (i == 6)} || {count, busy, expired, tc} !== exp_vec())
        $display("FAIL toggle_%0d got count=%0d tc=%b exp %0d %b", i, count, tc, (i >= 6) ? 0 : 4 - (i / 2 + 1), i == 6);
      else pass_cnt++;
    end
  endtask

  task automatic test_zero_load();
    start = 1'b1; load = '0; auto_reload = 1'b1; enable = 1'b1;
    step();
    start = 1'b0;
    total++;
    if ({count, busy, expired, tc} !== {W'(0), 3'b011})
      $display("FAIL zero_load got count=%0d busy=%b expired=%b tc=%b exp 0 0 1 1", count, busy, expired, tc);
    else pass_cnt++;
    step();
    total++;
    if ({count, busy, expired, tc} !== {W'(0), 3'b010})
      $display("FAIL zero_after got count=%0d busy=%b expired=%b tc=%b exp 0 0 1 0", count, busy, expired, tc);
    else pass_cnt++;
    auto_reload = 1'b0;
  endtask

  task automatic test_stop();
    start = 1'b1; load = W'(10); enable = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    stop = 1'b1;
    step();
    total++;
    if ({count, busy, expired} !== {W'(7), 2'b00})
      $display("FAIL stop_idle got count=%0d busy=%b expired=%b exp 7 0 0", count, busy, expired);
    else pass_cnt++;
    stop = 1'b0;
    repeat (2) step();
    total++;
    if ({count, busy} !== {W'(7), 1'b0})
      $display("FAIL idle_hold got count=%0d busy=%b exp 7 0", count, busy);
    else pass_cnt++;
    start = 1'b1; stop = 1'b1; load = W'(9);
    step();
    start = 1'b0; stop = 1'b0;
    total++;
    if ({count, busy, tc} !== {W'(9), 2'b10})
      $display("FAIL start_over_stop got count=%0d busy=%b tc=%b exp 9 1 0", count, busy, tc);
    else pass_cnt++;
  endtask

  task automatic test_async_reset_and_max();
    start = 1'b1; load = W'(4); enable = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #2 reset = 1'b1;
    #1;
    model_reset();
    total++;
    if ({count, busy, expired, tc} !== {W'(0), 3'b000})
      $display("FAIL midrun_reset got count=%0d busy=%b expired=%b tc=%b exp all zero", count, busy, expired, tc);
    else pass_cnt++;
    step();
    total++;
    if ({count, busy, expired, tc} !== {W'(0), 3'b000})
      $display("FAIL reset_no_tc got count=%0d tc=%b exp 0 0", count, tc);
    else pass_cnt++;
    reset = 1'b0;
    start = 1'b1; load = W'(4095);
    step();
    start = 1'b0;
    total++;
    if ({count, busy} !== {12'hFFF, 1'b1})
      $display("FAIL max_load got count=%h busy=%b exp fff 1", count, busy);
    else pass_cnt++;
    step();
    total++;
    if (count !== 12'hFFE)
      $display("FAIL max_dec got count=%h exp ffe", count);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 11) == 0);
      stop = ($urandom_range(0, 19) == 0);
      enable = ($urandom_range(0, 3) != 0);
      auto_reload = $urandom_range(0, 1);
      load = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
      step();
      total++;
      if ({count, busy, expired, tc} !== exp_vec())
        $display("FAIL rand_%0d got count=%0d busy=%b expired=%b tc=%b exp count=%0d state=%0d tc=%b", i, count, busy, expired, tc, m_count, m_state, m_tc);
      else pass_cnt++;
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_auto_reload();
    test_enable_toggle();
    test_zero_load();
    test_stop();
    test_async_reset_and_max();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/down_timer12.md
DOWN_TIMER12 -- requirements
Module: down_timer12

Interface
REQ-001 SHALL have parameter WIDTH, default 12, counter/load width in bits.
REQ-002 SHALL have clk input 1: rising-edge clock.
REQ-003 SHALL have reset input 1: asynchronous, active-high reset.
REQ-004 SHALL have enable input 1: decrement qualifier; count holds when low.
REQ-005 SHALL have start input 1: capture load and begin timing.
REQ-006 SHALL have stop input 1: abort timing, return to IDLE, hold count.
REQ-007 SHALL have auto_reload input 1: on expiry, reload and continue.
REQ-008 SHALL have load input WIDTH: initial/reload value.
REQ-009 SHALL have count output WIDTH: current remaining count, registered.
REQ-010 SHALL have busy output 1: high while state is RUN.
REQ-011 SHALL have expired output 1: high while state is DONE.
REQ-012 SHALL have tc output 1: registered one-cycle terminal-count pulse.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; all outputs registered.
REQ-014 Any state, start=1 SHALL set count<=load, reload_reg<=load, state<=RUN, tc<=0 next edge.
REQ-015 start SHALL take priority over stop, enable and expiry in the same cycle.
REQ-016 start with load==0 SHALL go to DONE with count=0 and tc=1 next edge; no reload regardless of auto_reload.
REQ-017 RUN, stop=1 (start=0) SHALL go to IDLE, count held, tc=0.
REQ-018 RUN, enable=1, count>1 SHALL decrement count by 1 per cycle.
REQ-019 RUN, enable=1, count==1, auto_reload=0 SHALL set count<=0, tc<=1, state<=DONE.
REQ-020 RUN, enable=1, count==1, auto_reload=1 SHALL set count<=reload_reg, tc<=1, stay RUN.
REQ-021 RUN, enable=0 SHALL hold count and state; tc=0.
REQ-022 Latency: count loaded to value N with enable held high SHALL pulse tc exactly N edges after the start edge.
REQ-023 tc SHALL be 0 in every cycle not covered by REQ-016, REQ-019, REQ-020.
REQ-024 count SHALL never wrap below 0; decrement from 0 is impossible by construction.
REQ-025 IDLE and DONE SHALL ignore enable and stop; count held.
REQ-026 load changes SHALL affect nothing except on a start cycle.
REQ-027 auto_reload SHALL be sampled at the expiry edge only.

Reset
REQ-028 reset=1 SHALL immediately force state=IDLE, count=0, reload_reg=0, tc=0, busy=0, expired=0.
REQ-029 reset asserted mid-RUN SHALL abort without a tc pulse.
REQ-030 After reset release, first start SHALL behave per REQ-014.

Structure
REQ-031 State encoding localparams (IDLE, RUN, DONE) and the default WIDTH SHALL live in a shared package with the counter blocks.
REQ-032 Block SHALL be a single module; no sub-modules.
REQ-033 Single clocked process for state/count/tc; busy/expired decoded from registered state.

Verification
REQ-034 reset; start, load=5, enable=1 -> count 5,4,3,2,1,0; tc high one cycle at count=0; expired=1 thereafter.
REQ-035 load=3, auto_reload=1, enable=1 for 10 cycles -> count 3,2,1,3,2,1,3...; tc every 3 cycles; busy stays 1.
REQ-036 load=4, enable toggled 1,0,1,0 -> count decrements only on enabled cycles; tc after 4 enabled cycles.
REQ-037 load=0 start -> next cycle count=0, tc=1, expired=1 with auto_reload=1.
REQ-038 RUN at count=7: stop -> IDLE, count=7, busy=0; start and stop same cycle with load=9 -> RUN, count=9.
REQ-039 reset asserted at count=2 between clock edges -> outputs zero immediately, no tc; WIDTH=12 start load=4095 counts down from 12'hFFF.
